// File: rtl/i2c_req_arbiter.sv
// Two-requester front end for a single I2C master.
// Arbitrates req0/req1 round-robin, sequences start/transfer/stop on the
// master controls, counts bytes, watches for slave NACK and for a stalled
// master (idle timeout), and reports completion with done/err.
module i2c_req_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       mode0,
  input  logic       mode1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  output logic [1:0] gnt,
  output logic       wnext,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       done,
  output logic       err,
  output logic       m_en,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_mode,
  output logic [6:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic       m_byte_done,
  input  logic       m_nack,
  input  logic       m_idle,
  input  logic [7:0] m_rdata
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_XFER  = 3'd2,
    S_ABORT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // A zero byte count still moves one byte.
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    if (len == 4'd0) begin
      return 4'd1;
    end else begin
      return len;
    end
  endfunction

  state_t     state_r, state_nx;
  logic [1:0] gnt_r, gnt_nx;
  logic       ptr_r, ptr_nx;
  logic       mode_r, mode_nx;
  logic [6:0] addr_r, addr_nx;
  logic [3:0] len_r, len_nx;
  logic [3:0] cnt_r, cnt_nx;
  logic [7:0] to_r, to_nx;
  logic       errf_r, errf_nx;
  logic [7:0] rdata_r, rdata_nx;
  logic       en_r, en_nx;
  logic       start_r, start_nx;
  logic       stop_r, stop_nx;
  logic       wnext_r, wnext_nx;
  logic       rvalid_r, rvalid_nx;
  logic       done_r, done_nx;
  logic       err_r, err_nx;
  logic       sel1_s;
  logic [7:0] m_wdata_s;

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state, datapath and next-output decode. Outputs are computed for
  // the upcoming state so that after registering they line up with it.
  always_comb begin
    state_nx  = state_r;
    gnt_nx    = gnt_r;
    ptr_nx    = ptr_r;
    mode_nx   = mode_r;
    addr_nx   = addr_r;
    len_nx    = len_r;
    cnt_nx    = cnt_r;
    to_nx     = to_r;
    errf_nx   = errf_r;
    rdata_nx  = rdata_r;
    en_nx     = 1'b0;
    start_nx  = 1'b0;
    stop_nx   = 1'b0;
    wnext_nx  = 1'b0;
    rvalid_nx = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    // Pointer names the favoured requester; the other wins only if the
    // favoured one is not asking.
    sel1_s    = ptr_r ? req1 : ~req0;

    case (state_r)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_nx   = sel1_s ? 2'b10 : 2'b01;
          mode_nx  = sel1_s ? mode1 : mode0;
          addr_nx  = sel1_s ? addr1 : addr0;
          len_nx   = sel1_s ? eff_len(len1) : eff_len(len0);
          cnt_nx   = 4'd0;
          to_nx    = 8'd0;
          errf_nx  = 1'b0;
          state_nx = S_START;
          en_nx    = 1'b1;
          start_nx = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end

      S_START: begin
        to_nx    = 8'd0;
        state_nx = S_XFER;
        en_nx    = 1'b1;
      end

      S_XFER: begin
        if (stop_r && m_idle) begin
          // Master has finished the stop condition.
          state_nx = S_DONE;
          done_nx  = 1'b1;
          err_nx   = errf_r;
        end else begin
          en_nx   = 1'b1;
          stop_nx = stop_r;
          if (m_byte_done) begin
            to_nx = 8'd0;
            // Once stop is requested no further bytes are accounted.
            if (!stop_r && (cnt_r < len_r)) begin
              cnt_nx = cnt_r + 4'd1;
              if ((cnt_r + 4'd1) == len_r) begin
                stop_nx = 1'b1;
              end else begin
                stop_nx = stop_r;
              end
              if (mode_r) begin
                rdata_nx  = m_rdata;
                rvalid_nx = 1'b1;
              end else if (!m_nack && ((cnt_r + 4'd1) < len_r)) begin
                wnext_nx = 1'b1;
              end else begin
                wnext_nx = 1'b0;
              end
            end else begin
              cnt_nx = cnt_r;
            end
          end else begin
            to_nx = to_r + 8'd1;
          end
          // NACK handled after byte accounting so a shared cycle still counts.
          if (m_nack) begin
            errf_nx = 1'b1;
            stop_nx = 1'b1;
          end else begin
            errf_nx = errf_r;
          end
          if (!m_byte_done && ((to_r + 8'd1) == TIMEOUT_C)) begin
            state_nx = S_ABORT;
            en_nx    = 1'b0;
            stop_nx  = 1'b1;
            errf_nx  = 1'b1;
          end else begin
            state_nx = S_XFER;
          end
        end
      end

      S_ABORT: begin
        errf_nx  = 1'b1;
        state_nx = S_DONE;
        done_nx  = 1'b1;
        err_nx   = 1'b1;
      end

      S_DONE: begin
        state_nx = S_IDLE;
        gnt_nx   = 2'b00;
        // Favour whoever was not just served.
        ptr_nx   = gnt_r[0];
        mode_nx  = 1'b0;
        addr_nx  = 7'd0;
      end

      default: begin
        state_nx = S_IDLE;
        gnt_nx   = 2'b00;
      end
    endcase
  end

  // Transaction context and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_r    <= 2'b00;
      ptr_r    <= 1'b0;
      mode_r   <= 1'b0;
      addr_r   <= 7'd0;
      len_r    <= 4'd0;
      cnt_r    <= 4'd0;
      to_r     <= 8'd0;
      errf_r   <= 1'b0;
      rdata_r  <= 8'd0;
      en_r     <= 1'b0;
      start_r  <= 1'b0;
      stop_r   <= 1'b0;
      wnext_r  <= 1'b0;
      rvalid_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      gnt_r    <= gnt_nx;
      ptr_r    <= ptr_nx;
      mode_r   <= mode_nx;
      addr_r   <= addr_nx;
      len_r    <= len_nx;
      cnt_r    <= cnt_nx;
      to_r     <= to_nx;
      errf_r   <= errf_nx;
      rdata_r  <= rdata_nx;
      en_r     <= en_nx;
      start_r  <= start_nx;
      stop_r   <= stop_nx;
      wnext_r  <= wnext_nx;
      rvalid_r <= rvalid_nx;
      done_r   <= done_nx;
      err_r    <= err_nx;
    end
  end

  // Write byte follows the granted requester directly, so the writer can
  // update wdata as soon as it sees wnext.
  always_comb begin
    m_wdata_s = 8'd0;
    case (gnt_r)
      2'b01:   m_wdata_s = wdata0;
      2'b10:   m_wdata_s = wdata1;
      default: m_wdata_s = 8'd0;
    endcase
  end

  assign gnt     = gnt_r;
  assign wnext   = wnext_r;
  assign rdata   = rdata_r;
  assign rvalid  = rvalid_r;
  assign done    = done_r;
  assign err     = err_r;
  assign m_en    = en_r;
  assign m_start = start_r;
  assign m_stop  = stop_r;
  assign m_mode  = mode_r;
  assign m_addr  = addr_r;
  assign m_wdata = m_wdata_s;

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the idle clk cycles allowed between master byte events before abort; legal range 1..255.
REQ-002 Reset reset_n SHALL be asynchronous, active-low; clock clk.
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req0, req1  in  1 each  transaction request, held high until the matching done pulse.
REQ-006 mode0, mode1  in  1 each  1=read, 0=write.
REQ-007 addr0, addr1  in  7 each  slave address.
REQ-008 wdata0, wdata1  in  8 each  current write byte.
REQ-009 len0, len1  in  4 each  byte count; 0 treated as 1.
REQ-010 gnt  out  2  one-hot grant, bit i = requester i.
REQ-011 wnext  out  1  pulse: granted writer presents next byte.
REQ-012 rdata  out  8  read byte; rvalid  out  1  pulse, rdata valid.
REQ-013 done  out  1  pulse, transaction end; err  out  1  pulse with done on NACK or timeout.
REQ-014 m_en, m_start, m_stop, m_mode  out  1 each  master controls.
REQ-015 m_addr  out  7; m_wdata  out  8  master address and write byte.
REQ-016 m_byte_done  in  1  master pulse, byte+ack slot complete; m_nack  in  1  pulse, slave NACK.
REQ-017 m_idle  in  1  master in idle/done state; m_rdata  in  8  master read byte.

Function
REQ-018 States SHALL be IDLE, START, XFER, ABORT, DONE; encoding free.
REQ-019 IDLE: if any req high, grant by round-robin; pointer favours requester not granted last; tie after reset goes to 0.
REQ-020 On grant, the block SHALL latch mode, addr, and effective len into internal registers; the byte counter SHALL be cleared; next state START.
REQ-021 START: m_en=1 and m_start=1 for exactly one cycle; next state XFER.
REQ-022 XFER: m_en=1 and m_start=0; each m_byte_done SHALL increment the byte counter (4-bit, no wrap beyond len).
REQ-023 m_stop SHALL assert on the cycle after the m_byte_done that completes byte len, and SHALL remain high until DONE.
REQ-024 Write: m_wdata = wdata of granted requester (combinational mux); wnext pulses with each m_byte_done when bytes remain.
REQ-025 Read: on m_byte_done, rdata <= m_rdata and rvalid pulses one cycle later.
REQ-026 m_nack in XFER: set error flag, assert m_stop, wait for m_idle.
REQ-027 In XFER, when m_stop=1 and m_idle=1, next state DONE.
REQ-028 Timeout counter (8-bit) SHALL clear on START and each m_byte_done, and increment in XFER otherwise; reaching TIMEOUT -> ABORT.
REQ-029 ABORT: m_en=0, m_stop=1 for one cycle; error flag set; next DONE.
REQ-030 DONE: done=1 and err=error flag for one cycle, gnt cleared, pointer updated, m_en=0; next IDLE.
REQ-031 gnt SHALL stay constant from grant through DONE; req changes mid-transaction SHALL be ignored.
REQ-032 m_byte_done and m_nack in the same cycle: count the byte, then NACK handling (no wnext).
REQ-033 req dropped while granted SHALL NOT abort; transaction completes.

Reset
REQ-034 Reset SHALL give state IDLE, gnt=0, and all pulses, m_* outputs, rdata, counters, pointer, and error flag at 0.
REQ-035 Reset mid-transaction SHALL immediately drop m_en, releasing the master.

Verification
REQ-036 req0 write, addr=0x50, len=2, two m_byte_done -> gnt=01, m_start for one cycle, one wnext, m_stop after byte 2, done with err=0.
REQ-037 req0 and req1 held together -> grants alternate 01,10,01 across three transactions.
REQ-038 req1 read, len=3, m_rdata=0xA5,0x3C,0xFF -> three rvalid with matching rdata, done.
REQ-039 m_nack on byte 1 of len=4 -> m_stop asserts; after m_idle, done=err=1, no further wnext.
REQ-040 TIMEOUT=10, no m_byte_done -> ABORT 10 cycles after START exit, then done=err=1.
REQ-041 reset_n low mid-XFER -> all outputs 0 asynchronously; after release, a new request is granted to requester 0.
